// File: rtl/miriscv_instr_encoder.sv
// miriscv_instr_encoder: turns abstract command requests into RV32I words for
// the miriscv stimulus path, with a one-word output buffer and LI expansion.
// Optional: define MIRISCV_ENC_RANGE_CHECK_EN to also flag immediates that do
// not fit their instruction field (the word is still emitted, truncated).
//
// state    | meaning
// EMPTY    | output register empty
// HOLD     | holding a final word
// HOLD_LUI | holding the LUI of an LI pair, ADDI word latched in addi_q
//
// Command codes: 0 NOP, 1-10 ADD SUB XOR OR AND SLL SRL SRA SLTS SLTU,
// 11-19 ADDI XORI ORI ANDI SLLI SRLI SRAI SLTI SLTIU, 20-24 LB LH LW LBU LHU,
// 25-27 SB SH SW, 28-33 BEQ BNE BLT BGE BLTU BGEU, 34 JAL, 35 JALR, 36 LUI,
// 37 AUIPC, 38 SYSTEM, 39 MISCMEM, 40 LI pseudo, 41-63 illegal.
module miriscv_instr_encoder #(
  parameter int CNT_W       = 16,
  parameter bit ILLEGAL_NOP = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [5:0]       req_cmd_i,
  input  logic [4:0]       req_rd_i,
  input  logic [4:0]       req_rs1_i,
  input  logic [4:0]       req_rs2_i,
  input  logic [31:0]      req_imm_i,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic [31:0]      instr_o,
  output logic             err_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] W_NOP    = 32'h0000_0013;
  localparam logic [31:0] W_ECALL  = 32'h0000_0073;
  localparam logic [31:0] W_EBREAK = 32'h0010_0073;
  localparam logic [31:0] W_FENCE  = 32'h0FF0_000F;

  typedef enum logic [1:0] {EMPTY, HOLD, HOLD_LUI} state_t;

  typedef enum logic [3:0] {
    CL_NOP, CL_R, CL_I, CL_SH, CL_LD, CL_ST, CL_BR, CL_JAL,
    CL_JALR, CL_LUI, CL_AUIPC, CL_SYS, CL_MISC, CL_LI, CL_ILL
  } cls_t;

  state_t      state_q;
  logic [31:0] addi_q;

  cls_t        cls;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] enc_word;
  logic [31:0] enc_addi;
  logic        enc_pair;
  logic        enc_has_word;
  logic        enc_illegal;
  logic        enc_misfit;
  logic [11:0] imm12;
  logic        fits12;
  logic [19:0] li_hi;
  logic        handshake;
  logic        accept;

  assign imm12  = req_imm_i[11:0];
  assign fits12 = (&req_imm_i[31:11]) | ~(|req_imm_i[31:11]);
  // (imm + 0x800) >> 12: the upper part plus the carry out of the low 12 bits
  assign li_hi  = req_imm_i[31:12] + {19'b0, req_imm_i[11]};

  assign handshake   = instr_valid_o & instr_ready_i;
  assign req_ready_o = (state_q == EMPTY) | ((state_q == HOLD) & instr_ready_i);
  assign accept      = req_valid_i & req_ready_o;

  // Command code -> instruction class plus funct3/funct7.
  always_comb begin
    cls = CL_ILL;
    f3  = 3'b000;
    f7  = 7'h00;
    case (req_cmd_i)
      6'd0:  cls = CL_NOP;
      6'd1:  cls = CL_R;
      6'd2:  begin cls = CL_R; f7 = 7'h20; end
      6'd3:  begin cls = CL_R; f3 = 3'b100; end
      6'd4:  begin cls = CL_R; f3 = 3'b110; end
      6'd5:  begin cls = CL_R; f3 = 3'b111; end
      6'd6:  begin cls = CL_R; f3 = 3'b001; end
      6'd7:  begin cls = CL_R; f3 = 3'b101; end
      6'd8:  begin cls = CL_R; f3 = 3'b101; f7 = 7'h20; end
      6'd9:  begin cls = CL_R; f3 = 3'b010; end
      6'd10: begin cls = CL_R; f3 = 3'b011; end
      6'd11: cls = CL_I;
      6'd12: begin cls = CL_I; f3 = 3'b100; end
      6'd13: begin cls = CL_I; f3 = 3'b110; end
      6'd14: begin cls = CL_I; f3 = 3'b111; end
      6'd15: begin cls = CL_SH; f3 = 3'b001; end
      6'd16: begin cls = CL_SH; f3 = 3'b101; end
      6'd17: begin cls = CL_SH; f3 = 3'b101; f7 = 7'h20; end
      6'd18: begin cls = CL_I; f3 = 3'b010; end
      6'd19: begin cls = CL_I; f3 = 3'b011; end
      6'd20: cls = CL_LD;
      6'd21: begin cls = CL_LD; f3 = 3'b001; end
      6'd22: begin cls = CL_LD; f3 = 3'b010; end
      6'd23: begin cls = CL_LD; f3 = 3'b100; end
      6'd24: begin cls = CL_LD; f3 = 3'b101; end
      6'd25: cls = CL_ST;
      6'd26: begin cls = CL_ST; f3 = 3'b001; end
      6'd27: begin cls = CL_ST; f3 = 3'b010; end
      6'd28: cls = CL_BR;
      6'd29: begin cls = CL_BR; f3 = 3'b001; end
      6'd30: begin cls = CL_BR; f3 = 3'b100; end
      6'd31: begin cls = CL_BR; f3 = 3'b101; end
      6'd32: begin cls = CL_BR; f3 = 3'b110; end
      6'd33: begin cls = CL_BR; f3 = 3'b111; end
      6'd34: cls = CL_JAL;
      6'd35: cls = CL_JALR;
      6'd36: cls = CL_LUI;
      6'd37: cls = CL_AUIPC;
      6'd38: cls = CL_SYS;
      6'd39: cls = CL_MISC;
      6'd40: cls = CL_LI;
      default: cls = CL_ILL;
    endcase
  end

  // Class -> instruction word(s); LI may produce a LUI plus a deferred ADDI.
  always_comb begin
    enc_word     = W_NOP;
    enc_addi     = W_NOP;
    enc_pair     = 1'b0;
    enc_has_word = 1'b1;
    enc_illegal  = 1'b0;
    case (cls)
      CL_NOP:   enc_word = W_NOP;
      CL_R:     enc_word = {f7, req_rs2_i, req_rs1_i, f3, req_rd_i, OP_R};
      CL_I:     enc_word = {imm12, req_rs1_i, f3, req_rd_i, OP_IMM};
      CL_SH:    enc_word = {f7, req_imm_i[4:0], req_rs1_i, f3, req_rd_i, OP_IMM};
      CL_LD:    enc_word = {imm12, req_rs1_i, f3, req_rd_i, OP_LOAD};
      CL_ST:    enc_word = {req_imm_i[11:5], req_rs2_i, req_rs1_i, f3,
                            req_imm_i[4:0], OP_STORE};
      CL_BR:    enc_word = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i, f3,
                            req_imm_i[4:1], req_imm_i[11], OP_BRANCH};
      CL_JAL:   enc_word = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11],
                            req_imm_i[19:12], req_rd_i, OP_JAL};
      CL_JALR:  enc_word = {imm12, req_rs1_i, 3'b000, req_rd_i, OP_JALR};
      CL_LUI:   enc_word = {req_imm_i[31:12], req_rd_i, OP_LUI};
      CL_AUIPC: enc_word = {req_imm_i[31:12], req_rd_i, OP_AUIPC};
      CL_SYS:   enc_word = req_imm_i[0] ? W_EBREAK : W_ECALL;
      CL_MISC:  enc_word = W_FENCE;
      CL_LI: begin
        if (fits12) begin
          enc_word = {imm12, 5'd0, 3'b000, req_rd_i, OP_IMM};
        end else if (imm12 == 12'd0) begin
          enc_word = {li_hi, req_rd_i, OP_LUI};
        end else begin
          enc_word = {li_hi, req_rd_i, OP_LUI};
          enc_addi = {imm12, req_rd_i, 3'b000, req_rd_i, OP_IMM};
          enc_pair = 1'b1;
        end
      end
      default: begin
        enc_illegal  = 1'b1;
        enc_has_word = ILLEGAL_NOP;
        enc_word     = W_NOP;
      end
    endcase
  end

`ifdef MIRISCV_ENC_RANGE_CHECK_EN
  logic fits13;
  logic fits21;
  assign fits13 = (&req_imm_i[31:12]) | ~(|req_imm_i[31:12]);
  assign fits21 = (&req_imm_i[31:20]) | ~(|req_imm_i[31:20]);

  // Flag immediates that lose information when packed into their field.
  always_comb begin
    enc_misfit = 1'b0;
    case (cls)
      CL_I, CL_LD, CL_ST, CL_JALR: enc_misfit = ~fits12;
      CL_BR:                       enc_misfit = ~fits13 | req_imm_i[0];
      CL_JAL:                      enc_misfit = ~fits21 | req_imm_i[0];
      CL_SH:                       enc_misfit = |req_imm_i[31:5];
      CL_LUI, CL_AUIPC:            enc_misfit = |imm12;
      default:                     enc_misfit = 1'b0;
    endcase
  end
`else
  assign enc_misfit = 1'b0;
`endif

  // Output buffer FSM: loads on accept, walks the LI pair, empties on handoff.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= EMPTY;
      instr_valid_o <= 1'b0;
      instr_o       <= '0;
      addi_q        <= '0;
      err_o         <= 1'b0;
    end else begin
      err_o <= accept & (enc_illegal | enc_misfit);
      case (state_q)
        EMPTY, HOLD: begin
          if (accept && enc_has_word) begin
            instr_o       <= enc_word;
            instr_valid_o <= 1'b1;
            addi_q        <= enc_addi;
            state_q       <= enc_pair ? HOLD_LUI : HOLD;
          end else if (handshake) begin
            instr_valid_o <= 1'b0;
            state_q       <= EMPTY;
          end
        end
        HOLD_LUI: begin
          if (handshake) begin
            instr_o <= addi_q;
            state_q <= HOLD;
          end
        end
        default: begin
          instr_valid_o <= 1'b0;
          state_q       <= EMPTY;
        end
      endcase
    end
  end

  // Count words handed to the consumer, wrapping naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_cnt_o <= '0;
    end else if (handshake) begin
      instr_cnt_o <= instr_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_miriscv_instr_encoder.sv
// Bench for miriscv_instr_encoder: directed vector table, hand sequences for
// backpressure and reset-in-pair, then randomized traffic against a model.
module tb_miriscv_instr_encoder;
  localparam int CNT_W       = 4;
  localparam bit ILLEGAL_NOP = 1'b1;
`ifdef MIRISCV_ENC_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic             clk_i;
  logic             rst_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [5:0]       req_cmd_i;
  logic [4:0]       req_rd_i;
  logic [4:0]       req_rs1_i;
  logic [4:0]       req_rs2_i;
  logic [31:0]      req_imm_i;
  logic             instr_valid_o;
  logic             instr_ready_i;
  logic [31:0]      instr_o;
  logic             err_o;
  logic [CNT_W-1:0] instr_cnt_o;

  miriscv_instr_encoder #(.CNT_W(CNT_W), .ILLEGAL_NOP(ILLEGAL_NOP)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_cmd_i    (req_cmd_i),
    .req_rd_i     (req_rd_i),
    .req_rs1_i    (req_rs1_i),
    .req_rs2_i    (req_rs2_i),
    .req_imm_i    (req_imm_i),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .instr_o      (instr_o),
    .err_o        (err_o),
    .instr_cnt_o  (instr_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int r_f3  [10] = '{0, 0, 4, 6, 7, 1, 5, 5, 2, 3};
  int i_f3  [9]  = '{0, 4, 6, 7, 1, 5, 5, 2, 3};
  int ld_f3 [5]  = '{0, 1, 2, 4, 5};
  int st_f3 [3]  = '{0, 1, 2};
  int br_f3 [6]  = '{0, 1, 4, 5, 6, 7};

  function automatic bit fits(input logic [31:0] v, input int bits);
    longint s;
    longint lim;
    s   = longint'($signed(v));
    lim = longint'(1) <<< (bits - 1);
    return (s >= -lim) && (s < lim);
  endfunction

  function automatic logic [31:0] i_word(input logic [31:0] imm, input int rs1, input int f3,
                                         input int rd, input int op);
    return ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) |
           (32'(rd) << 7) | 32'(op);
  endfunction

  function automatic void model(input int cmd, input int rd, input int rs1, input int rs2,
                                input logic [31:0] u, output int n, output logic [31:0] w0,
                                output logic [31:0] w1, output bit err);
    logic [31:0] f7;
    logic [31:0] hi;
    logic [31:0] t;
    n = 1; w0 = 32'h13; w1 = 32'h0; err = 1'b0;
    if (cmd == 0) begin
      w0 = 32'h13;
    end else if (cmd <= 10) begin
      f7 = (cmd == 2 || cmd == 8) ? 32'h20 : 32'h0;
      w0 = (f7 << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(r_f3[cmd-1]) << 12) |
           (32'(rd) << 7) | 32'h33;
    end else if (cmd <= 19) begin
      if (cmd >= 15 && cmd <= 17) begin
        w0  = i_word((u & 32'd31) | ((cmd == 17) ? 32'h400 : 32'h0), rs1, i_f3[cmd-11], rd, 'h13);
        err = RANGE_EN && ((u >> 5) != 0);
      end else begin
        w0  = i_word(u, rs1, i_f3[cmd-11], rd, 'h13);
        err = RANGE_EN && !fits(u, 12);
      end
    end else if (cmd <= 24) begin
      w0  = i_word(u, rs1, ld_f3[cmd-20], rd, 'h03);
      err = RANGE_EN && !fits(u, 12);
    end else if (cmd <= 27) begin
      w0  = (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
            (32'(st_f3[cmd-25]) << 12) | ((u & 32'h1F) << 7) | 32'h23;
      err = RANGE_EN && !fits(u, 12);
    end else if (cmd <= 33) begin
      w0  = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(rs2) << 20) |
            (32'(rs1) << 15) | (32'(br_f3[cmd-28]) << 12) | (((u >> 1) & 32'hF) << 8) |
            (((u >> 11) & 1) << 7) | 32'h63;
      err = RANGE_EN && (!fits(u, 13) || u[0]);
    end else if (cmd == 34) begin
      w0  = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20) |
            (((u >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | 32'h6F;
      err = RANGE_EN && (!fits(u, 21) || u[0]);
    end else if (cmd == 35) begin
      w0  = i_word(u, rs1, 0, rd, 'h67);
      err = RANGE_EN && !fits(u, 12);
    end else if (cmd == 36 || cmd == 37) begin
      w0  = (u & 32'hFFFFF000) | (32'(rd) << 7) | ((cmd == 36) ? 32'h37 : 32'h17);
      err = RANGE_EN && ((u & 32'hFFF) != 0);
    end else if (cmd == 38) begin
      w0 = u[0] ? 32'h00100073 : 32'h00000073;
    end else if (cmd == 39) begin
      w0 = 32'h0FF0000F;
    end else if (cmd == 40) begin
      if (fits(u, 12)) begin
        w0 = i_word(u, 0, 0, rd, 'h13);
      end else begin
        t  = u + 32'h800;
        hi = t >> 12;
        w0 = (hi << 12) | (32'(rd) << 7) | 32'h37;
        if ((u & 32'hFFF) != 0) begin
          n  = 2;
          w1 = i_word(u, rd, 0, rd, 'h13);
        end
      end
    end else begin
      err = 1'b1;
      n   = ILLEGAL_NOP ? 1 : 0;
      w0  = 32'h13;
    end
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [31:0]      exp_q[$];
  logic [31:0]      got_q[$];
  bit               err_pend = 1'b0;
  bit               err_seen = 1'b0;
  logic [CNT_W-1:0] cnt_exp  = '0;
  bit               prev_stall = 1'b0;
  logic [31:0]      prev_word  = '0;

  always @(negedge clk_i) begin
    int          mn;
    logic [31:0] mw0;
    logic [31:0] mw1;
    bit          me;
    if (rst_i) begin
      exp_q.delete();
      err_pend   = 1'b0;
      cnt_exp    = '0;
      prev_stall = 1'b0;
    end else begin
      chk("err_o", err_o, err_pend);
      if (err_o) err_seen = 1'b1;
      chk("instr_valid", instr_valid_o, exp_q.size() > 0);
      chk("instr_cnt", instr_cnt_o, cnt_exp);
      chk("req_ready", req_ready_o, (exp_q.size() == 0) || (exp_q.size() == 1 && instr_ready_i));
      if (prev_stall) chk("stall_stable", instr_o, prev_word);
      if (instr_valid_o && exp_q.size() > 0) chk("instr_word", instr_o, exp_q[0]);
      prev_stall = instr_valid_o && !instr_ready_i;
      prev_word  = instr_o;
      if (instr_valid_o && instr_ready_i) begin
        got_q.push_back(instr_o);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        cnt_exp = cnt_exp + 1'b1;
      end
      err_pend = 1'b0;
      if (req_valid_i && req_ready_o) begin
        model(int'(req_cmd_i), int'(req_rd_i), int'(req_rs1_i), int'(req_rs2_i), req_imm_i,
              mn, mw0, mw1, me);
        if (mn >= 1) exp_q.push_back(mw0);
        if (mn == 2) exp_q.push_back(mw1);
        err_pend = me;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int cmd, input int rd, input int rs1, input int rs2,
                      input logic [31:0] imm);
    bit ok;
    ok          = 1'b0;
    req_valid_i = 1'b1;
    req_cmd_i   = 6'(cmd);
    req_rd_i    = 5'(rd);
    req_rs1_i   = 5'(rs1);
    req_rs2_i   = 5'(rs2);
    req_imm_i   = imm;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: req_ready_o never rose for cmd %0d", cmd);
    end
  endtask

  typedef struct {
    int          cmd;
    int          rd;
    int          rs1;
    int          rs2;
    logic [31:0] imm;
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          err;
  } vec_t;

  vec_t        vecs[16];
  logic [31:0] edge_imm[10] = '{32'h0, 32'd2047, 32'hFFFFF800, 32'h800, 32'hFFFFF7FF,
                                32'h7FFFFFFF, 32'h80000000, 32'h7FFFF800, 32'hFFFFF000, 32'h1000};
  logic [CNT_W-1:0] c0;
  logic [CNT_W-1:0] dcnt;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1,  3, 1, 2, 32'h0,        1, 32'h002081B3, 32'h0, 1'b0};
    vecs[1]  = '{28, 7, 1, 2, 32'hFFFFFFFC, 1, 32'hFE208EE3, 32'h0, 1'b0};
    vecs[2]  = '{34, 1, 0, 5, 32'd2048,     1, 32'h001000EF, 32'h0, 1'b0};
    vecs[3]  = '{40, 5, 0, 0, 32'h12345FFF, 2, 32'h123462B7, 32'hFFF28293, 1'b0};
    vecs[4]  = '{40, 5, 0, 0, 32'h00005000, 1, 32'h000052B7, 32'h0, 1'b0};
    vecs[5]  = '{40, 5, 0, 0, 32'hFFFFFFFF, 1, 32'hFFF00293, 32'h0, 1'b0};
    vecs[6]  = '{45, 1, 2, 3, 32'h0,        1, 32'h00000013, 32'h0, 1'b1};
    vecs[7]  = '{38, 0, 0, 0, 32'h1,        1, 32'h00100073, 32'h0, 1'b0};
    vecs[8]  = '{38, 0, 0, 0, 32'h0,        1, 32'h00000073, 32'h0, 1'b0};
    vecs[9]  = '{39, 0, 0, 0, 32'h0,        1, 32'h0FF0000F, 32'h0, 1'b0};
    vecs[10] = '{0,  0, 0, 0, 32'h0,        1, 32'h00000013, 32'h0, 1'b0};
    vecs[11] = '{2,  1, 2, 3, 32'h0,        1, 32'h403100B3, 32'h0, 1'b0};
    vecs[12] = '{17, 1, 1, 0, 32'd3,        1, 32'h4030D093, 32'h0, 1'b0};
    vecs[13] = '{25, 9, 2, 3, 32'd8,        1, 32'h00310423, 32'h0, 1'b0};
    vecs[14] = '{20, 4, 1, 0, 32'hFFFFFFFF, 1, 32'hFFF08203, 32'h0, 1'b0};
    vecs[15] = '{36, 7, 0, 0, 32'hABCDE000, 1, 32'hABCDE3B7, 32'h0, 1'b0};

    rst_i = 1'b1; req_valid_i = 1'b0; instr_ready_i = 1'b1;
    req_cmd_i = '0; req_rd_i = '0; req_rs1_i = '0; req_rs2_i = '0; req_imm_i = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    @(negedge clk_i);
    chk("reset_valid", instr_valid_o, 32'h0);
    chk("reset_instr", instr_o, 32'h0);
    chk("reset_err", err_o, 32'h0);
    chk("reset_cnt", instr_cnt_o, 32'h0);
    @(posedge clk_i);
    #1;

    // Directed table, consumer always ready.
    for (int i = 0; i < 16; i++) begin
      got_q.delete();
      err_seen = 1'b0;
      c0 = instr_cnt_o;
      send(vecs[i].cmd, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      repeat (4) @(posedge clk_i);
      #1;
      chk($sformatf("vec%0d_nwords", i), got_q.size(), vecs[i].n);
      if (got_q.size() > 0) chk($sformatf("vec%0d_w0", i), got_q[0], vecs[i].w0);
      if (vecs[i].n == 2 && got_q.size() > 1) chk($sformatf("vec%0d_w1", i), got_q[1], vecs[i].w1);
      chk($sformatf("vec%0d_err", i), err_seen, vecs[i].err);
      dcnt = instr_cnt_o - c0;
      chk($sformatf("vec%0d_cnt", i), dcnt, vecs[i].n);
    end

    // ADDI with an immediate too wide for its field: truncated, error only with range check.
    got_q.delete();
    err_seen = 1'b0;
    send(11, 1, 0, 0, 32'd4096);
    repeat (3) @(posedge clk_i);
    #1;
    chk("addi4096_nwords", got_q.size(), 1);
    if (got_q.size() > 0) chk("addi4096_word", got_q[0], 32'h00000093);
    chk("addi4096_err", err_seen, RANGE_EN);

    // Backpressure: consumer stalls 5 cycles with a request pending.
    got_q.delete();
    instr_ready_i = 1'b0;
    send(11, 1, 0, 0, 32'd1);
    req_valid_i = 1'b1; req_cmd_i = 6'd11; req_rd_i = 5'd2; req_imm_i = 32'd2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      chk("stall_req_ready", req_ready_o, 32'h0);
      chk("stall_valid", instr_valid_o, 32'h1);
      chk("stall_word", instr_o, 32'h00100093);
    end
    @(posedge clk_i);
    #1 instr_ready_i = 1'b1;
    send(11, 2, 0, 0, 32'd2);
    send(11, 3, 0, 0, 32'd3);
    send(11, 4, 0, 0, 32'd4);
    repeat (3) @(posedge clk_i);
    #1;
    chk("stall_nwords", got_q.size(), 4);
    for (int k = 0; k < 4 && k < got_q.size(); k++)
      chk($sformatf("stall_order%0d", k), got_q[k],
          (32'(k + 1) << 20) | (32'(k + 1) << 7) | 32'h13);

    // Reset while the LUI of an LI pair is held: the ADDI must never appear.
    got_q.delete();
    instr_ready_i = 1'b0;
    send(40, 5, 0, 0, 32'h12345FFF);
    @(negedge clk_i);
    chk("pair_lui_held", instr_o, 32'h123462B7);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("pair_reset_valid", instr_valid_o, 32'h0);
    @(posedge clk_i);
    #1 instr_ready_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    chk("pair_reset_nwords", got_q.size(), 0);

    // Randomized traffic against the model, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      int r;
      @(posedge clk_i);
      #1;
      rst_i         = ($urandom_range(0, 499) == 0);
      instr_ready_i = ($urandom_range(0, 3) != 0);
      req_valid_i   = $urandom_range(0, 1);
      r = $urandom_range(0, 99);
      if (r < 80)      req_cmd_i = 6'($urandom_range(0, 39));
      else if (r < 92) req_cmd_i = 6'd40;
      else             req_cmd_i = 6'($urandom_range(41, 63));
      req_rd_i  = 5'($urandom);
      req_rs1_i = 5'($urandom);
      req_rs2_i = 5'($urandom);
      r = $urandom_range(0, 3);
      if (r == 0)      req_imm_i = 32'($urandom_range(0, 4095)) - 32'd2048;
      else if (r == 1) req_imm_i = $urandom;
      else if (r == 2) req_imm_i = $urandom & 32'hFFFFF000;
      else             req_imm_i = edge_imm[$urandom_range(0, 9)];
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0; req_valid_i = 1'b0; instr_ready_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
